icache_axi_reader: RTL and testbench

Read-side responder for the instruction-cache refill port. It accepts one cache-line read request at a time from the icache (`cpu_ren`/`cpu_raddr`) and fetches the 16-byte line from memory as a 4-beat, 32-bit AXI4 INCR burst. It then returns the assembled 128-bit line to the icache with a one-cycle `dev_rvalid` pulse. It sits between the icache and the core's AXI read arbiter, and it never aborts a transaction once that transaction is accepted.

---
 rtl/icache_axi_reader.sv | 146 ++++++++++++++
 tb/tb_icache_axi_reader.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_axi_reader.sv
// icache_axi_reader: fetches one 16-byte icache line as a 4-beat 32-bit AXI4
// INCR burst and hands the assembled 128-bit line back with a single pulse.
// Every output is a register or a decode of the state register, so no input
// reaches an output combinationally.
module icache_axi_reader #(
  parameter logic [3:0] AXI_ID = 4'd0
) (
  input  logic         clk,
  input  logic         rst,
  // icache side
  input  logic         cpu_ren,
  input  logic [31:0]  cpu_raddr,
  output logic         dev_rrdy,
  output logic         ren_received,
  output logic         dev_rvalid,
  output logic [127:0] dev_rdata,
  output logic         dev_rerr,
  output logic         flush_flag_valid,
  // AXI read address channel
  output logic [31:0]  araddr,
  output logic         arvalid,
  input  logic         arready,
  output logic [7:0]   arlen,
  output logic [2:0]   arsize,
  output logic [1:0]   arburst,
  output logic [3:0]   arid,
  // AXI read data channel
  input  logic [31:0]  rdata,
  input  logic [1:0]   rresp,
  input  logic         rlast,
  input  logic         rvalid,
  output logic         rready,
  input  logic [3:0]   rid
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADDR = 2'd1;
  localparam logic [1:0] DATA = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  logic [1:0]  state_reg, state_next;
  logic [31:0] addr_reg, addr_next;
  logic [1:0]  beat_reg, beat_next;
  logic        err_reg, err_next;
  logic        ren_received_reg, ren_received_next;
  logic        beat_wr;

  // The burst ID on the read data channel and the byte offset within the
  // line carry no information for this block.
  logic unused_inputs;
  assign unused_inputs = ^{rid, cpu_raddr[3:0]};

  // A beat is captured on every data handshake; rready is high exactly in DATA.
  assign beat_wr = (state_reg == DATA) && rvalid;

  // Next-state logic: accept in IDLE, hold AR until arready, count four beats.
  always_comb begin
    state_next        = state_reg;
    addr_next         = addr_reg;
    beat_next         = beat_reg;
    err_next          = err_reg;
    ren_received_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (cpu_ren) begin
          addr_next         = {cpu_raddr[31:4], 4'b0000};
          ren_received_next = 1'b1;
          beat_next         = 2'd0;
          err_next          = 1'b0;
          state_next        = ADDR;
        end
      end
      ADDR: begin
        if (arready) begin
          state_next = DATA;
        end
      end
      DATA: begin
        if (rvalid) begin
          beat_next = beat_reg + 2'd1;
          // A bad response or an rlast on the wrong beat marks the line bad,
          // but the burst is still drained to its fourth beat.
          if ((rresp != 2'b00) || (rlast != (beat_reg == 2'd3))) begin
            err_next = 1'b1;
          end
          if (beat_reg == 2'd3) begin
            state_next = RESP;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Control registers, cleared asynchronously so a mid-burst reset drops AXI valids at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg        <= IDLE;
      addr_reg         <= '0;
      beat_reg         <= '0;
      err_reg          <= 1'b0;
      ren_received_reg <= 1'b0;
    end else begin
      state_reg        <= state_next;
      addr_reg         <= addr_next;
      beat_reg         <= beat_next;
      err_reg          <= err_next;
      ren_received_reg <= ren_received_next;
    end
  end

  // One 32-bit lane register per beat; a lane keeps its value until the next
  // burst overwrites it, so dev_rdata stays stable between lines.
  for (genvar gi = 0; gi < 4; gi++) begin : lane_g
    localparam logic [1:0] LANE = 2'(gi);
    logic [31:0] lane_reg;

    // Capture rdata when this lane's beat is handshaken.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        lane_reg <= '0;
      end else if (beat_wr && (beat_reg == LANE)) begin
        lane_reg <= rdata;
      end
    end

    assign dev_rdata[32*gi +: 32] = lane_reg;
  end

  assign dev_rrdy         = (state_reg == IDLE);
  assign ren_received     = ren_received_reg;
  assign dev_rvalid       = (state_reg == RESP);
  assign dev_rerr         = (state_reg == RESP) && err_reg;
  assign flush_flag_valid = (state_reg != IDLE);

  assign araddr  = addr_reg;
  assign arvalid = (state_reg == ADDR);
  assign arlen   = 8'd3;
  assign arsize  = 3'b010;
  assign arburst = 2'b01;
  assign arid    = AXI_ID;
  assign rready  = (state_reg == DATA);

endmodule

// File: tb/tb_icache_axi_reader.sv
// Testbench for icache_axi_reader: acts as icache and AXI slave, predicts the
// returned line, error flag and latency from the burst contents it issues.
module tb_icache_axi_reader;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         cpu_ren = 1'b0;
  logic [31:0]  cpu_raddr = '0;
  logic         dev_rrdy, ren_received, dev_rvalid, dev_rerr, flush_flag_valid;
  logic [127:0] dev_rdata;
  logic [31:0]  araddr;
  logic         arvalid;
  logic         arready = 1'b0;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic [3:0]   arid;
  logic [31:0]  rdata = '0;
  logic [1:0]   rresp = '0;
  logic         rlast = 1'b0;
  logic         rvalid = 1'b0;
  logic         rready;
  logic [3:0]   rid = '0;

  icache_axi_reader #(.AXI_ID(4'd0)) dut (
    .clk(clk), .rst(rst),
    .cpu_ren(cpu_ren), .cpu_raddr(cpu_raddr),
    .dev_rrdy(dev_rrdy), .ren_received(ren_received), .dev_rvalid(dev_rvalid),
    .dev_rdata(dev_rdata), .dev_rerr(dev_rerr), .flush_flag_valid(flush_flag_valid),
    .araddr(araddr), .arvalid(arvalid), .arready(arready), .arlen(arlen),
    .arsize(arsize), .arburst(arburst), .arid(arid),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
    .rready(rready), .rid(rid)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int ar_count = 0;
  logic arvalid_prev = 1'b0;
  int last_ren_cyc = 0;
  int last_resp_cyc = 0;

  // Burst the AXI slave will return: data, response and rlast per beat.
  logic [31:0] bd [4];
  logic [1:0]  br [4];
  logic [3:0]  bl;

  always @(posedge clk) cyc++;

  // Count address requests as rising edges of arvalid.
  always @(negedge clk) begin
    if (arvalid && !arvalid_prev) ar_count++;
    arvalid_prev = arvalid;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // Full transaction: accept, AR with ar_delay stalls, four beats with optional
  // rvalid gaps (0 none, 1 toggling, 2 random), optional cpu_ren noise in DATA.
  task automatic run_txn(input logic [31:0] addr, input int ar_delay,
                         input int gaps, input bit ren_noise, input string name);
    logic [31:0]  exp_addr;
    logic [127:0] exp_line;
    logic         exp_err;
    int n, k, gap_cnt, ar0, guard;
    exp_addr = {addr[31:4], 4'h0};
    exp_line = {bd[3], bd[2], bd[1], bd[0]};
    exp_err  = (bl != 4'b1000);
    for (int i = 0; i < 4; i++) if (br[i] != 2'b00) exp_err = 1'b1;
    ar0 = ar_count;

    checks++;
    if (dev_rrdy !== 1'b1) begin
      errors++; $display("FAIL %s idle_rrdy: got %b, required 1", name, dev_rrdy);
    end
    cpu_ren = 1'b1; cpu_raddr = addr;
    @(negedge clk); n = 1;
    cpu_ren = 1'b0; cpu_raddr = $urandom;
    last_ren_cyc = cyc;
    checks++;
    if ({ren_received, arvalid, flush_flag_valid, dev_rrdy} !== 4'b1110 || araddr !== exp_addr) begin
      errors++;
      $display("FAIL %s t1: got ren/arv/flush/rrdy=%b araddr=%h, required 1110 araddr=%h",
               name, {ren_received, arvalid, flush_flag_valid, dev_rrdy}, araddr, exp_addr);
    end
    checks++;
    if ({arlen, arsize, arburst, arid} !== {8'd3, 3'b010, 2'b01, 4'd0}) begin
      errors++;
      $display("FAIL %s ar_fields: got len=%0d size=%b burst=%b id=%h, required 3 010 01 0",
               name, arlen, arsize, arburst, arid);
    end
    arready = (ar_delay == 0);
    for (int i = 0; i < ar_delay; i++) begin
      @(negedge clk); n++;
      cpu_raddr = $urandom;
      checks++;
      if ({arvalid, ren_received, flush_flag_valid} !== 3'b101 || araddr !== exp_addr) begin
        errors++;
        $display("FAIL %s ar_hold: got arv/ren/flush=%b araddr=%h, required 101 araddr=%h",
                 name, {arvalid, ren_received, flush_flag_valid}, araddr, exp_addr);
      end
      arready = (i == ar_delay - 1);
    end
    @(negedge clk); n++;
    arready = 1'b0;
    checks++;
    if ({rready, arvalid} !== 2'b10) begin
      errors++; $display("FAIL %s data_entry: got rready/arvalid=%b, required 10", name, {rready, arvalid});
    end

    k = 0; gap_cnt = 0; guard = 0;
    while (k < 4 && guard < 100) begin
      guard++;
      if ((gaps == 1 && (guard % 2) == 0) || (gaps == 2 && $urandom_range(0, 1) == 1)) begin
        rvalid = 1'b0; rdata = $urandom; rresp = 2'($urandom_range(0, 3)); rlast = 1'($urandom_range(0, 1));
        gap_cnt++;
      end else begin
        rvalid = 1'b1; rdata = bd[k]; rresp = br[k]; rlast = bl[k];
      end
      if (ren_noise) begin cpu_ren = 1'b1; cpu_raddr = $urandom; end
      @(negedge clk); n++;
      if (rvalid) k++;
      if (k < 4) begin
        checks++;
        if ({rready, dev_rvalid, flush_flag_valid} !== 3'b101) begin
          errors++;
          $display("FAIL %s data_hold: got rready/rvalid/flush=%b, required 101",
                   name, {rready, dev_rvalid, flush_flag_valid});
        end
      end
    end
    rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; cpu_ren = 1'b0;
    if (guard >= 100) begin
      checks++; errors++; $display("FAIL %s beat_timeout: got %0d beats, required 4", name, k);
    end

    last_resp_cyc = cyc;
    checks++;
    if ({dev_rvalid, flush_flag_valid, rready} !== 3'b110) begin
      errors++;
      $display("FAIL %s resp: got rvalid/flush/rready=%b, required 110", name, {dev_rvalid, flush_flag_valid, rready});
    end
    checks++;
    if (dev_rdata !== exp_line || dev_rerr !== exp_err) begin
      errors++;
      $display("FAIL %s line: got %h err=%b, required %h err=%b", name, dev_rdata, dev_rerr, exp_line, exp_err);
    end
    checks++;
    if (n != 6 + ar_delay + gap_cnt) begin
      errors++; $display("FAIL %s latency: got %0d, required %0d", name, n, 6 + ar_delay + gap_cnt);
    end
    checks++;
    if (ar_count != ar0 + 1) begin
      errors++; $display("FAIL %s ar_count: got %0d, required %0d", name, ar_count - ar0, 1);
    end
    @(negedge clk);
    checks++;
    if ({dev_rvalid, dev_rrdy, flush_flag_valid, dev_rerr} !== 4'b0100 || dev_rdata !== exp_line) begin
      errors++;
      $display("FAIL %s after_resp: got rvalid/rrdy/flush/err=%b data=%h, required 0100 data=%h",
               name, {dev_rvalid, dev_rrdy, flush_flag_valid, dev_rerr}, dev_rdata, exp_line);
    end
    $display("txn %s addr=%h line=%h err=%b cycles=%0d", name, exp_addr, exp_line, exp_err, n);
  endtask

  task automatic good_burst();
    for (int i = 0; i < 4; i++) begin bd[i] = $urandom; br[i] = 2'b00; end
    bl = 4'b1000;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({dev_rrdy, ren_received, dev_rvalid, dev_rerr, flush_flag_valid, arvalid, rready} !== 7'b1000000
        || araddr !== 32'h0 || dev_rdata !== 128'h0) begin
      errors++;
      $display("FAIL reset: got flags=%b araddr=%h data=%h, required 1000000 0 0",
               {dev_rrdy, ren_received, dev_rvalid, dev_rerr, flush_flag_valid, arvalid, rready}, araddr, dev_rdata);
    end
    rst = 1'b1;
    @(negedge clk);
    $display("txn reset released");
  endtask

  task automatic test_single();
    bd[0] = 32'h11; bd[1] = 32'h22; bd[2] = 32'h33; bd[3] = 32'h44;
    for (int i = 0; i < 4; i++) br[i] = 2'b00;
    bl = 4'b1000;
    run_txn(32'h1C00_0014, 0, 0, 1'b0, "single");
  endtask

  task automatic test_stall();
    good_burst();
    run_txn(32'h8000_1238, 5, 1, 1'b0, "stall");
  endtask

  task automatic test_errors();
    good_burst(); br[1] = 2'b10;
    run_txn(32'h0000_4440, 0, 0, 1'b0, "rresp_err");
    good_burst(); bl = 4'b0000;
    run_txn(32'h0000_5550, 1, 0, 1'b0, "no_rlast");
    good_burst(); bl = 4'b1010;
    run_txn(32'h0000_6660, 0, 2, 1'b0, "early_rlast");
  endtask

  task automatic test_ignore_ren();
    int ar0;
    good_burst();
    ar0 = ar_count;
    run_txn(32'hABCD_0000, 0, 0, 1'b1, "ren_noise");
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (ren_received !== 1'b0 || arvalid !== 1'b0) begin
        errors++; $display("FAIL ren_noise_quiet: got ren=%b arvalid=%b, required 0 0", ren_received, arvalid);
      end
    end
    checks++;
    if (ar_count != ar0 + 1) begin
      errors++; $display("FAIL ren_noise_ars: got %0d, required 1", ar_count - ar0);
    end
  endtask

  task automatic test_withdraw();
    int ar0;
    ar0 = ar_count;
    #1 cpu_ren = 1'b1; cpu_raddr = 32'h1234_5670;
    #2 cpu_ren = 1'b0;
    repeat (5) begin
      @(negedge clk);
      checks++;
      if ({ren_received, arvalid, flush_flag_valid, dev_rrdy} !== 4'b0001) begin
        errors++;
        $display("FAIL withdraw: got ren/arv/flush/rrdy=%b, required 0001", {ren_received, arvalid, flush_flag_valid, dev_rrdy});
      end
    end
    checks++;
    if (ar_count != ar0) begin
      errors++; $display("FAIL withdraw_ars: got %0d, required 0", ar_count - ar0);
    end
    $display("txn withdraw no_request");
  endtask

  task automatic test_back_to_back();
    int resp1;
    good_burst();
    run_txn(32'h0000_0000, 0, 0, 1'b0, "b2b_first");
    resp1 = last_resp_cyc;
    good_burst();
    run_txn(32'h0000_0010, 0, 0, 1'b0, "b2b_second");
    checks++;
    if (last_ren_cyc <= resp1 + 1) begin
      errors++; $display("FAIL b2b_gap: got ren at %0d, required after %0d", last_ren_cyc, resp1 + 1);
    end
  endtask

  task automatic test_reset_mid();
    good_burst();
    cpu_ren = 1'b1; cpu_raddr = 32'h5555_0000;
    @(negedge clk);
    cpu_ren = 1'b0; arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    rvalid = 1'b1; rdata = bd[0]; rresp = 2'b00; rlast = 1'b0;
    @(negedge clk);
    rdata = bd[1];
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({dev_rrdy, ren_received, dev_rvalid, dev_rerr, flush_flag_valid, arvalid, rready} !== 7'b1000000
        || araddr !== 32'h0 || dev_rdata !== 128'h0) begin
      errors++;
      $display("FAIL reset_mid: got flags=%b araddr=%h data=%h, required 1000000 0 0",
               {dev_rrdy, ren_received, dev_rvalid, dev_rerr, flush_flag_valid, arvalid, rready}, araddr, dev_rdata);
    end
    rvalid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    $display("txn reset_mid aborted");
    good_burst();
    run_txn(32'h5555_0020, 2, 2, 1'b0, "after_reset");
  endtask

  task automatic test_random();
    for (int t = 0; t < 8; t++) begin
      good_burst();
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 5) == 0) br[i] = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 4) == 0) bl = 4'($urandom_range(0, 15));
      run_txn($urandom, $urandom_range(0, 3), 2, 1'($urandom_range(0, 1)), "random");
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stall();
    test_errors();
    test_ignore_ren();
    test_withdraw();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
